// File: rtl/load_extend_ctrl.sv
// Load unit: takes one load, does a word read, returns the extended value.
// Ports: clk_i/rst_i, req_* from EX/MEM, mem_* to dmem, rsp_* to writeback.
module load_extend_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [4:0]  req_rd_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic [4:0]  rsp_rd_o,
    output logic        rsp_fault_o
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] F_LB  = 3'b000;
    localparam logic [2:0] F_LH  = 3'b001;
    localparam logic [2:0] F_LW  = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100;
    localparam logic [2:0] F_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [2:0]      f3_q, f3_d;
    logic [4:0]      rd_q, rd_d;
    logic [31:0]     data_q, data_d;
    logic            fault_q, fault_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            req_bad;
    logic [7:0]      op_b;
    logic [15:0]     op_h;
    logic [31:0]     ext;

    // Requests that fault before touching memory.
    always_comb begin
        req_bad = 1'b0;
        unique case (req_funct3_i)
            F_LB, F_LBU: req_bad = 1'b0;
            F_LH, F_LHU: req_bad = req_addr_i[0];
            F_LW:        req_bad = |req_addr_i[1:0];
            default:     req_bad = 1'b1;
        endcase
    end

    // Operand extraction from the returned word.
    always_comb begin
        op_b = 8'h00;
        unique case (addr_q[1:0])
            2'd0: op_b = mem_rdata_i[7:0];
            2'd1: op_b = mem_rdata_i[15:8];
            2'd2: op_b = mem_rdata_i[23:16];
            2'd3: op_b = mem_rdata_i[31:24];
            default: op_b = 8'h00;
        endcase
        op_h = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        ext = 32'h0;
        unique case (f3_q)
            F_LB:    ext = {{24{op_b[7]}}, op_b};
            F_LH:    ext = {{16{op_h[15]}}, op_h};
            F_LW:    ext = mem_rdata_i;
            F_LBU:   ext = {24'h0, op_b};
            F_LHU:   ext = {16'h0, op_h};
            default: ext = 32'h0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        data_d  = data_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d = req_addr_i;
                    f3_d   = req_funct3_i;
                    rd_d   = req_rd_i;
                    cnt_d  = '0;
                    data_d = 32'h0;
                    if (req_bad) begin
                        fault_d = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        fault_d = 1'b0;
                        state_d = S_MEM;
                    end
                end
            end
            S_MEM: begin
                // An ack in the last allowed cycle still completes the load.
                if (mem_ack_i) begin
                    data_d  = ext;
                    fault_d = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = 32'h0;
                    fault_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= 32'h0;
            f3_q    <= 3'h0;
            rd_q    <= 5'h0;
            data_q  <= 32'h0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign mem_req_o   = (state_q == S_MEM);
    assign mem_addr_o  = mem_req_o ? {addr_q[31:2], 2'b00} : 32'h0;
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_data_o  = data_q;
    assign rsp_rd_o    = rd_q;
    assign rsp_fault_o = fault_q;

endmodule

// File: tb/tb_load_extend_ctrl.sv
// Randomized bench for load_extend_ctrl with a behavioural load model.
// Drives #1 after posedge and samples in the same window.
module tb_load_extend_ctrl;

    localparam int TO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic [2:0]  req_funct3_i;
    logic [4:0]  req_rd_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic [4:0]  rsp_rd_o;
    logic        rsp_fault_o;

    int n_tests = 0;
    int n_fail  = 0;

    load_extend_ctrl #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_funct3_i(req_funct3_i),
        .req_rd_i(req_rd_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_rd_o(rsp_rd_o),
        .rsp_fault_o(rsp_fault_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic bit is_bad(input logic [31:0] a,
                                  input logic [2:0] f);
        int unsigned off = a % 4;
        if (!(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        if ((f == 3'd1 || f == 3'd5) && (off % 2) != 0) return 1'b1;
        if (f == 3'd2 && off != 0) return 1'b1;
        return 1'b0;
    endfunction

    // {fault, data}
    function automatic logic [32:0] model(input logic [31:0] a,
                                          input logic [2:0] f,
                                          input logic [31:0] w,
                                          input bit acked);
        int unsigned off = a % 4;
        logic [31:0] v;
        if (is_bad(a, f) || !acked) return {1'b1, 32'h0};
        v = w;
        case (f)
            3'd0, 3'd4: begin
                v = (w >> (8 * off)) % 256;
                if (f == 3'd0 && v >= 128) v = v - 256;
            end
            3'd1, 3'd5: begin
                v = (w >> (8 * off)) % 65536;
                if (f == 3'd1 && v >= 32768) v = v - 65536;
            end
            default: v = w;
        endcase
        return {1'b0, v};
    endfunction

    task automatic do_load(input logic [31:0] a, input logic [2:0] f,
                           input logic [4:0] rd, input logic [31:0] w,
                           input int ack_at, input int hold);
        logic [32:0] exp;
        bit early;
        int n;
        int want;
        early = is_bad(a, f);
        chk("req_ready_idle", req_ready_o, 1);
        req_valid_i  = 1'b1;
        req_addr_i   = a;
        req_funct3_i = f;
        req_rd_i     = rd;
        step();
        req_valid_i  = 1'b0;
        req_addr_i   = $urandom;
        req_funct3_i = 3'($urandom);
        req_rd_i     = 5'($urandom);
        n = 0;
        while (mem_req_o === 1'b1 && n < TO + 4) begin
            chk("mem_addr", mem_addr_o, {a[31:2], 2'b00});
            mem_ack_i   = (n == ack_at);
            mem_rdata_i = (n == ack_at) ? w : $urandom;
            step();
            n++;
        end
        mem_ack_i = 1'b0;
        want = early ? 0 : (ack_at < TO ? ack_at + 1 : TO);
        chk("mem_cycles", n, want);
        exp = model(a, f, w, ack_at < TO);
        for (int i = 0; i <= hold; i++) begin
            chk("rsp_valid", rsp_valid_o, 1);
            chk("rsp_data", rsp_data_o, exp[31:0]);
            chk("rsp_rd", rsp_rd_o, rd);
            chk("rsp_fault", rsp_fault_o, exp[32]);
            chk("req_ready_resp", req_ready_o, 0);
            chk("mem_req_resp", mem_req_o, 0);
            rsp_ready_i  = (i == hold);
            req_valid_i  = 1'b1;
            req_funct3_i = 3'd2;
            req_addr_i   = $urandom & 32'hFFFF_FFFC;
            mem_ack_i    = 1'($urandom);
            mem_rdata_i  = $urandom;
            step();
        end
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b0;
        mem_ack_i   = 1'b0;
        chk("rsp_valid_done", rsp_valid_o, 0);
        chk("req_ready_done", req_ready_o, 1);
        chk("mem_req_done", mem_req_o, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  f;
        int          ack_at;
        int          r;
        rst_i = 1'b1;
        req_valid_i = 1'b0;
        req_addr_i = 32'h0;
        req_funct3_i = 3'h0;
        req_rd_i = 5'h0;
        mem_ack_i = 1'b0;
        mem_rdata_i = 32'h0;
        rsp_ready_i = 1'b0;
        step();
        step();
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_data", rsp_data_o, 0);
        chk("rst_rsp_rd", rsp_rd_o, 0);
        chk("rst_rsp_fault", rsp_fault_o, 0);
        rst_i = 1'b0;
        step();

        do_load(32'h103, 3'd0, 5'd9, 32'h80FF_1234, 0, 0);
        do_load(32'h202, 3'd5, 5'd3, 32'h9ABC_0000, 1, 0);
        do_load(32'h202, 3'd1, 5'd4, 32'h9ABC_0000, 0, 1);
        do_load(32'h204, 3'd2, 5'd5, 32'hDEAD_BEEF, 2, 0);
        do_load(32'h101, 3'd1, 5'd6, 32'h1234_5678, 0, 0);
        do_load(32'h102, 3'd2, 5'd7, 32'h1234_5678, 0, 0);
        do_load(32'h100, 3'd3, 5'd8, 32'h1234_5678, 0, 0);
        do_load(32'h300, 3'd2, 5'd10, 32'hCAFE_F00D, TO + 5, 0);
        do_load(32'h301, 3'd4, 5'd11, 32'hCAFE_F00D, TO - 1, 0);
        do_load(32'h306, 3'd1, 5'd12, 32'h8001_7FFF, 0, 5);

        // Reset while a read is outstanding; a late ack must be dropped.
        req_valid_i  = 1'b1;
        req_addr_i   = 32'h400;
        req_funct3_i = 3'd2;
        req_rd_i     = 5'd13;
        step();
        req_valid_i = 1'b0;
        chk("pre_rst_mem_req", mem_req_o, 1);
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("mid_rst_mem_req", mem_req_o, 0);
        chk("mid_rst_rsp_valid", rsp_valid_o, 0);
        chk("mid_rst_req_ready", req_ready_o, 1);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h5555_AAAA;
        step();
        mem_ack_i = 1'b0;
        chk("stale_ack_rsp_valid", rsp_valid_o, 0);
        chk("stale_ack_mem_req", mem_req_o, 0);
        chk("stale_ack_req_ready", req_ready_o, 1);
        step();
        chk("stale_ack_rsp_valid2", rsp_valid_o, 0);

        for (int k = 0; k < 300; k++) begin
            a = $urandom;
            if ($urandom_range(0, 9) < 8) begin
                r = $urandom_range(0, 4);
                f = (r < 2) ? 3'(r) : 3'(r + 1);
            end else begin
                f = 3'($urandom);
            end
            if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
            r = $urandom_range(0, 9);
            if (r < 6) ack_at = $urandom_range(0, 3);
            else if (r < 8) ack_at = $urandom_range(0, TO - 1);
            else ack_at = TO + $urandom_range(0, 3);
            do_load(a, f, 5'($urandom), $urandom, ack_at,
                    $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_extend_ctrl.md
# load_extend_ctrl

Load-unit controller for the RV32IC core. It accepts one load request at a time from the execute stage and issues a word-aligned read to data memory. It then extracts the addressed byte or halfword, sign- or zero-extends it to 32 bits, and returns the result with the destination register over a valid/ready handshake. It also detects misaligned, illegal and timed-out loads and sits between the EX/MEM pipeline register and the data-memory port.

## Interface
- TIMEOUT, 16, number of consecutive MEM cycles without mem_ack before the load faults (legal range 2..256).
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  load request present
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_addr  in  32  byte address of the load
- req_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other codes are illegal
- req_rd  in  5  destination register index
- mem_req  out  1  read request to data memory
- mem_addr  out  32  word-aligned read address {addr[31:2],2'b00}
- mem_ack  in  1  read data valid this cycle
- mem_rdata  in  32  read data word
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  32  extended load result (0 when faulted)
- rsp_rd  out  5  destination register of the response
- rsp_fault  out  1  load faulted (misaligned, illegal or timeout)

## Operation
- FSM states: IDLE, MEM, RESP. Outputs are Moore-decoded from state and registers.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, funct3 and rd.
  - If funct3 is illegal, or LH/LHU with addr[0]=1, or LW with addr[1:0]≠0: go to RESP with fault=1 and data=0. No memory access is made.
  - Otherwise go to MEM with the timeout counter at 0.
- MEM:
  - mem_req=1 and mem_addr=latched aligned address.
  - On mem_ack, extract the operand and go to RESP with fault=0:
    - Byte: mem_rdata[8k+7:8k] with k=addr[1:0].
    - Halfword: mem_rdata[16h+15:16h] with h=addr[1].
    - LB/LH replicate the operand MSB into the upper bits. LBU/LHU fill the upper bits with 0. LW passes the word unchanged.
  - Without mem_ack, the counter increments. If the counter equals TIMEOUT-1 with no ack, go to RESP with fault=1 and data=0.
  - mem_ack wins over a coincident timeout.
- RESP:
  - rsp_valid=1.
  - rsp_data, rsp_rd and rsp_fault are stable until rsp_valid&&rsp_ready.
  - On that handshake, go to IDLE.
- mem_ack outside MEM is ignored.
- req_valid outside IDLE is ignored; req_ready=0 there.
- Reset values:
  - State=IDLE, so req_ready=1.
  - mem_req=0, mem_addr=0.
  - rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_fault=0.
  - Counter=0.

## Timing
- Request accepted at edge N. mem_req is high in cycle N+1.
- If the ack is sampled at edge M, rsp_valid is high from cycle M+1.
- A fault from a misaligned or illegal request gives rsp_valid in cycle N+1, with mem_req never asserted.
- Best-case throughput is one load per 3 cycles: accept, MEM with immediate ack, RESP with immediate ready. IDLE follows, so req_ready is high the cycle after the response handshake.
- Timeout: mem_req is held for exactly TIMEOUT cycles, then rsp_valid rises with fault=1.
- Reset mid-operation, from any state: at the edge with rst=1 the block goes to IDLE.
  - Next cycle: mem_req=0 and rsp_valid=0.
  - The in-flight load is dropped.
  - A late mem_ack is ignored.
- rsp_ready held low keeps RESP indefinitely with outputs unchanged. No new request is accepted meanwhile.

## Test plan
- LB addr=0x103, mem_rdata=0x80FF_1234 with ack on the first MEM cycle → rsp_data=0xFFFF_FF80, rsp_rd as issued, fault=0, mem_addr=0x100, rsp_valid 2 cycles after acceptance.
- LHU addr=0x202 and LH addr=0x202, mem_rdata=0x9ABC_0000 → LHU gives 0x0000_9ABC, LH gives 0xFFFF_9ABC. LW addr=0x204, data 0xDEAD_BEEF → 0xDEAD_BEEF.
- Misaligned LH addr=0x101, LW addr=0x102, illegal funct3=011 → fault=1, data=0, mem_req never asserted, rsp_valid the cycle after acceptance.
- TIMEOUT=16, no ack → mem_req high 16 cycles, then rsp_valid with fault=1. Repeat with ack on the 16th MEM cycle → fault=0, valid data.
- Backpressure: rsp_ready low for 5 cycles → rsp_valid and outputs stable, req_ready=0. A new req_valid is ignored until one cycle after the handshake, then accepted.
- Assert rst during MEM, then pulse mem_ack after reset → next cycle mem_req=0 and rsp_valid=0, req_ready=1, and the stale ack produces no response.
